// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg
//   Shared encodings for the shared-port arbiter and its tag FIFO.
//   - owner_e : tag stored per accepted request (0 = fetch, 1 = load/store)
//   - lock_e  : state of the address-phase lock (open / held)
//   - SIZE_*  : sram-like transfer size encodings
package sram_port_arbiter_pkg;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   typedef enum logic {
      LOCK_OPEN = 1'b0,
      LOCK_HELD = 1'b1
   } lock_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_port_arbiter_tag_fifo.sv
// tag_fifo
//   In-order 1-bit tag FIFO recording which requester owns each accepted
//   request. Pointers carry an extra wrap bit so full and empty are told
//   apart without a separate flag.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_tag  enqueue a tag (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   full, empty     occupancy flags
//   head            tag at the read pointer
module tag_fifo
   import sram_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Wrap-bit pointers make the difference the exact occupancy.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == {(AW + 1){1'b0}});
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next-state for storage and pointers; push and pop may both happen.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_tag;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= {DEPTH{1'b0}};
         wr_ptr_q <= {(AW + 1){1'b0}};
         rd_ptr_q <= {(AW + 1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one sram-like port between instruction fetch (inst_*) and
//   load/store (data_*). Load/store wins by default; a fetch that has lost
//   STARVE_LIMIT consecutive cycles takes priority. A request offered but not
//   yet accepted locks the grant so the address phase stays stable. Every
//   acceptance pushes its owner into an in-order tag FIFO which steers the
//   matching response back to the right requester.
// Ports:
//   clk, reset                           clock, async active-high reset
//   inst_req/addr, inst_addr_ok          fetch address phase
//   inst_data_ok, inst_rdata             fetch response
//   data_req/wr/size/addr/wstrb/wdata    load/store address phase
//   data_addr_ok, data_data_ok, rdata    load/store handshake and response
//   mem_*                                shared downstream port
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT) + 1;
   localparam logic [SW-1:0] STARVE_THR = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_MAX = {SW{1'b1}};
   localparam logic [SW-1:0] STARVE_ONE = {{(SW - 1){1'b0}}, 1'b1};

   lock_e         lock_q, lock_d;
   owner_e        grant_q, grant_d;
   logic [SW-1:0] starve_q, starve_d;

   owner_e        winner;
   owner_e        grant_sel;
   owner_e        head_owner;
   logic          accept;
   logic          inst_accept;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_head;

   // Fresh winner: fetch only when starved, otherwise load/store if present.
   always_comb begin
      winner = OWNER_INST;
      if (inst_req && (starve_q >= STARVE_THR)) begin
         winner = OWNER_INST;
      end else if (data_req) begin
         winner = OWNER_DATA;
      end else begin
         winner = OWNER_INST;
      end
   end

   // A held lock freezes the grant until the pending request is accepted.
   always_comb begin
      grant_sel = winner;
      if (lock_q == LOCK_HELD) begin
         grant_sel = grant_q;
      end else begin
         grant_sel = winner;
      end
   end

   assign mem_req      = (inst_req | data_req) & ~fifo_full & ~reset;
   assign accept       = mem_req & mem_addr_ok;
   assign inst_accept  = accept & (grant_sel == OWNER_INST);
   assign inst_addr_ok = inst_accept;
   assign data_addr_ok = accept & (grant_sel == OWNER_DATA);

   // Drive the shared port from the granted requester; fetch is a word read.
   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = SIZE_WORD;
      mem_addr  = 32'h0000_0000;
      mem_wstrb = 4'h0;
      mem_wdata = 32'h0000_0000;
      if (reset) begin
         mem_size = 2'b00;
      end else begin
         case (grant_sel)
            OWNER_DATA: begin
               mem_wr    = data_wr;
               mem_size  = data_size;
               mem_addr  = data_addr;
               mem_wstrb = data_wstrb;
               mem_wdata = data_wdata;
            end
            OWNER_INST: begin
               mem_wr    = 1'b0;
               mem_size  = SIZE_WORD;
               mem_addr  = inst_addr;
               mem_wstrb = 4'h0;
               mem_wdata = 32'h0000_0000;
            end
            default: begin
               mem_size = 2'b00;
            end
         endcase
      end
   end

   // Lock next-state: capture the winner on a refused offer, release on accept.
   always_comb begin
      lock_d  = lock_q;
      grant_d = grant_q;
      case (lock_q)
         LOCK_OPEN: begin
            if (mem_req && !mem_addr_ok) begin
               lock_d  = LOCK_HELD;
               grant_d = grant_sel;
            end else begin
               lock_d = LOCK_OPEN;
            end
         end
         LOCK_HELD: begin
            if (accept) begin
               lock_d = LOCK_OPEN;
            end else begin
               lock_d = LOCK_HELD;
            end
         end
         default: begin
            lock_d  = LOCK_OPEN;
            grant_d = OWNER_DATA;
         end
      endcase
   end

   // Starvation counter: counts consecutive lost fetch cycles, saturating.
   always_comb begin
      starve_d = starve_q;
      if (inst_req && !inst_accept) begin
         if (starve_q == STARVE_MAX) begin
            starve_d = starve_q;
         end else begin
            starve_d = starve_q + STARVE_ONE;
         end
      end else begin
         starve_d = {SW{1'b0}};
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q   <= LOCK_OPEN;
         grant_q  <= OWNER_DATA;
         starve_q <= {SW{1'b0}};
      end else begin
         lock_q   <= lock_d;
         grant_q  <= grant_d;
         starve_q <= starve_d;
      end
   end

   tag_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_tag (grant_sel == OWNER_DATA),
      .pop      (mem_data_ok),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   // Responses are steered by the oldest tag; a response with no tag is dropped.
   assign head_owner   = owner_e'(fifo_head);
   assign inst_data_ok = mem_data_ok & ~fifo_empty & ~reset & (head_owner == OWNER_INST);
   assign data_data_ok = mem_data_ok & ~fifo_empty & ~reset & (head_owner == OWNER_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   localparam int OUTSTANDING  = 4;
   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .OUTSTANDING  (OUTSTANDING),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model + compare ----------------
   // Model state: outstanding owners in acceptance order, a pending-offer
   // owner (the request that was refused and must be repeated), and the
   // number of consecutive cycles a fetch has been kept waiting.
   bit m_tags[$];
   bit m_pending     = 1'b0;
   bit m_pend_owner  = 1'b1;
   int m_lost        = 0;

   always @(negedge clk) begin : compare_proc
      bit          full_now;
      bit          exp_req;
      bit          own;
      bit          acc;
      bit          pop;
      bit          hd;
      logic [70:0] exp_pl;
      logic [70:0] act_pl;
      if (reset) begin
         check("reset_outputs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
         m_tags.delete();
         m_pending    = 1'b0;
         m_pend_owner = 1'b1;
         m_lost       = 0;
      end else begin
         full_now = (m_tags.size() >= OUTSTANDING);
         exp_req  = (inst_req || data_req) && !full_now;
         if (m_pending)                              own = m_pend_owner;
         else if (inst_req && m_lost >= STARVE_LIMIT) own = 1'b0;
         else if (data_req)                          own = 1'b1;
         else                                        own = 1'b0;
         acc = exp_req && mem_addr_ok;
         pop = mem_data_ok && (m_tags.size() > 0);
         hd  = pop ? m_tags[0] : 1'b0;

         check("mem_req", mem_req, exp_req);
         check("inst_addr_ok", inst_addr_ok, acc && !own);
         check("data_addr_ok", data_addr_ok, acc && own);
         check("inst_data_ok", inst_data_ok, pop && !hd);
         check("data_data_ok", data_data_ok, pop && hd);
         check("rdata_route", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
         if (exp_req) begin
            exp_pl = own ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                         : {1'b0, 2'd2, inst_addr, 4'h0, 32'h0};
            act_pl = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
            check("mem_payload", act_pl, exp_pl);
         end

         if (pop) void'(m_tags.pop_front());
         if (acc) m_tags.push_back(own);
         if (acc) begin
            m_pending = 1'b0;
         end else if (exp_req && !m_pending) begin
            m_pending    = 1'b1;
            m_pend_owner = own;
         end
         if (inst_req && !(acc && !own)) m_lost = m_lost + 1;
         else                            m_lost = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req    = 1'b0;
      inst_addr   = 32'h0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_size   = 2'd2;
      data_addr   = 32'h0;
      data_wstrb  = 4'h0;
      data_wdata  = 32'h0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
   endtask

   task automatic drain(input int n);
      inst_req    = 1'b0;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      for (int i = 0; i < n; i++) begin
         mem_data_ok = 1'b1;
         mem_rdata   = $urandom;
         step();
      end
      mem_data_ok = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int  lost;
      bit  won;
      bit  hs_i;
      bit  hs_d;
      int  resp_cnt;
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_mem_req", mem_req, 1'b0);
      step();
      reset = 1'b0;

      // T1: both request; data wins, inst next, response routed to data.
      inst_req = 1'b1; inst_addr = 32'h100;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h200;
      mem_addr_ok = 1'b1;
      @(negedge clk);
      check("t1_data_wins", {inst_addr_ok, data_addr_ok}, 2'b01);
      check("t1_addr", mem_addr, 32'h200);
      step(); data_req = 1'b0;
      @(negedge clk);
      check("t1_inst_next", inst_addr_ok, 1'b1);
      step(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t1_resp_data", {inst_data_ok, data_data_ok}, 2'b01);
      check("t1_rdata", data_rdata, 32'hDEAD_BEEF);
      step(); mem_rdata = 32'h1;
      @(negedge clk);
      check("t1_resp_inst", {inst_data_ok, data_data_ok}, 2'b10);
      step(); mem_data_ok = 1'b0;

      // T2: refused inst offer locks the port against a later data request.
      inst_req = 1'b1; inst_addr = 32'h300;
      @(negedge clk);
      check("t2_offer", {mem_req, mem_addr}, {1'b1, 32'h300});
      step(); data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h400; data_wstrb = 4'hF; data_wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check("t2_lock_c1", mem_addr, 32'h300);
      step();
      @(negedge clk);
      check("t2_lock_c2", mem_addr, 32'h300);
      step(); mem_addr_ok = 1'b1;
      @(negedge clk);
      check("t2_inst_acc", {inst_addr_ok, data_addr_ok}, 2'b10);
      step(); inst_req = 1'b0;
      @(negedge clk);
      check("t2_data_acc", {data_addr_ok, mem_wr}, 2'b11);
      step(); data_wr = 1'b0; data_wstrb = 4'h0;
      drain(2);

      // T3: four fetches fill the tag FIFO.
      inst_req = 1'b1; mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h1000 + 32'(i * 4);
         @(negedge clk);
         check("t3_fill", inst_addr_ok, 1'b1);
         step();
      end
      @(negedge clk);
      check("t3_full_blocks", {mem_req, inst_addr_ok}, 2'b00);
      step(); mem_data_ok = 1'b1; mem_rdata = 32'h77;
      @(negedge clk);
      check("t3_pop", {inst_data_ok, mem_req}, 2'b10);
      step(); mem_data_ok = 1'b0;
      @(negedge clk);
      check("t3_refill", inst_addr_ok, 1'b1);
      step();
      @(negedge clk);
      check("t3_full_again", mem_req, 1'b0);
      step();
      drain(4);

      // T4: mixed order inst, store, inst, load; responses 1..4.
      mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h10;
      @(negedge clk); check("t4_acc0", inst_addr_ok, 1'b1);
      step(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h20; data_wstrb = 4'h3; data_wdata = 32'h1234;
      @(negedge clk); check("t4_acc1", data_addr_ok, 1'b1);
      step(); data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b1; inst_addr = 32'h30;
      @(negedge clk); check("t4_acc2", inst_addr_ok, 1'b1);
      step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h40; data_size = 2'd0; data_wstrb = 4'h0;
      @(negedge clk); check("t4_acc3", data_addr_ok, 1'b1);
      step(); data_req = 1'b0; data_size = 2'd2; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         mem_rdata = 32'(k);
         @(negedge clk);
         check("t4_order", {inst_data_ok, data_data_ok}, (k % 2 == 1) ? 2'b10 : 2'b01);
         check("t4_rdata", (k % 2 == 1) ? inst_rdata : data_rdata, 32'(k));
         step();
      end
      mem_data_ok = 1'b0;

      // T5: data held high; inst wins after exactly STARVE_LIMIT losses.
      inst_req = 1'b1; inst_addr = 32'h500;
      data_req = 1'b1; data_addr = 32'h600; mem_addr_ok = 1'b1;
      lost = 0; won = 1'b0;
      for (int c = 0; c < 20 && !won; c++) begin
         if (c > 0) mem_data_ok = 1'b1;
         @(negedge clk);
         if (inst_addr_ok) won = 1'b1;
         else if (data_addr_ok) lost++;
         step();
      end
      check("t5_inst_won", won, 1'b1);
      check("t5_lost_cycles", lost, 32'd8);
      inst_addr = 32'h504;
      @(negedge clk);
      check("t5_data_regains", {inst_addr_ok, data_addr_ok}, 2'b01);
      step();
      drain(1);

      // T6: asynchronous reset with two outstanding.
      mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h70;
      step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h80;
      step(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h90; mem_data_ok = 1'b1; mem_rdata = 32'h66;
      #1;
      check("t6_pre_reset", {mem_req, inst_data_ok}, 2'b11);
      #1 reset = 1'b1;
      #1;
      check("t6_async_zero", {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
      step(); reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      @(negedge clk);
      check("t6_stray_dropped", {inst_data_ok, data_data_ok}, 2'b00);
      step(); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'hA0; mem_addr_ok = 1'b1;
      @(negedge clk);
      check("t6_rearb", data_addr_ok, 1'b1);
      step(); data_req = 1'b0;
      drain(1);

      // Randomized traffic with held requests and an in-order memory.
      hs_i = 1'b0; hs_d = 1'b0; resp_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 599) == 0) begin
            reset    = 1'b1;
            resp_cnt = 0;
         end
         if (hs_i || !inst_req) begin
            inst_req  = ($urandom_range(0, 99) < 50);
            inst_addr = $urandom;
         end
         if (hs_d || !data_req) begin
            data_req   = ($urandom_range(0, 99) < 75);
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wstrb = 4'($urandom);
            data_wdata = $urandom;
         end
         mem_addr_ok = ($urandom_range(0, 99) < 70);
         if (resp_cnt > 0) mem_data_ok = ($urandom_range(0, 99) < 60);
         else              mem_data_ok = ($urandom_range(0, 99) < 5);
         mem_rdata = $urandom;
         @(negedge clk);
         hs_i = inst_addr_ok;
         hs_d = data_addr_ok;
         if (!reset) begin
            if (mem_data_ok && resp_cnt > 0) resp_cnt--;
            if (mem_req && mem_addr_ok) resp_cnt++;
         end
         step();
      end

      idle_inputs();
      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
